// File: rtl/convkxk_stream.sv
// convkxk_stream: KxK streaming convolution with frame-aware window validity,
// valid/ready backpressure and frame-boundary coefficient commit. Build macro CONV_ABS_OUT_EN selects |result| output.
module convkxk_stream #(
  parameter int PIXEL_WIDTH  = 8,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int COEFF_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 8,
  parameter int SHIFT_WIDTH  = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         s_valid,
  output logic                                         s_ready,
  input  logic [PIXEL_WIDTH-1:0]                       s_data,
  input  logic                                         s_sof,
  output logic                                         m_valid,
  input  logic                                         m_ready,
  output logic [OUTPUT_WIDTH-1:0]                      m_data,
  output logic                                         m_sof,
  output logic                                         m_eol,
  output logic                                         m_eof,
  input  logic                                         coef_we,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]   coef_addr,
  input  logic [COEFF_WIDTH-1:0]                       coef_wdata,
  input  logic                                         coef_commit,
  input  logic [SHIFT_WIDTH-1:0]                       scale_shift,
  output logic                                         frame_err
);
  localparam int K      = KERNEL_SIZE;
  localparam int KK     = K * K;
  localparam int AW     = $clog2(KK);
  localparam int RW     = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int CLW    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int PROD_W = PIXEL_WIDTH + COEFF_WIDTH + 1;
  localparam int ACC_W  = PIXEL_WIDTH + COEFF_WIDTH + 2 * $clog2(K) + 1;
  localparam int CENTRE = (K / 2) * K + K / 2;
  localparam logic [RW-1:0]  LAST_ROW = RW'(IMAGE_HEIGHT - 1);
  localparam logic [CLW-1:0] LAST_COL = CLW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0]  WIN_ROW  = RW'(K - 1);
  localparam logic [CLW-1:0] WIN_COL  = CLW'(K - 1);
  localparam logic [AW-1:0]  KK_A     = AW'(KK);
`ifdef CONV_ABS_OUT_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((longint'(1) << OUTPUT_WIDTH) - 1);
`else
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((longint'(1) << (OUTPUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(longint'(1) << (OUTPUT_WIDTH - 1)));
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t                        state_q, state_d;
  logic [RW-1:0]                 row_q, row_d, p_row;
  logic [CLW-1:0]                col_q, col_d, p_col;
  logic                          en, acc_px, win_ok, copy_en;
  logic                          pend_q, pend_d, err_q, err_d;
  logic [SHIFT_WIDTH-1:0]        shift_q, shift_d;
  logic signed [COEFF_WIDTH-1:0] shadow_q [KK];
  logic signed [COEFF_WIDTH-1:0] shadow_d [KK];
  logic signed [COEFF_WIDTH-1:0] active_q [KK];
  logic signed [COEFF_WIDTH-1:0] active_d [KK];
  logic [PIXEL_WIDTH-1:0]        lb_q [K-1][IMAGE_WIDTH];
  logic [PIXEL_WIDTH-1:0]        lb_col_d [K-1];
  logic [PIXEL_WIDTH-1:0]        col_new [K];
  logic [PIXEL_WIDTH-1:0]        win_q [K][K];
  logic [PIXEL_WIDTH-1:0]        win_d [K][K];
  logic                          v1_q, v1_d, sof1_q, sof1_d, eol1_q, eol1_d, eof1_q, eof1_d;
  logic signed [PROD_W-1:0]      prod_q [KK];
  logic signed [PROD_W-1:0]      prod_d [KK];
  logic [SHIFT_WIDTH-1:0]        sh1_q, sh1_d;
  logic                          m_valid_q, m_valid_d, m_sof_q, m_sof_d;
  logic                          m_eol_q, m_eol_d, m_eof_q, m_eof_d;
  logic [OUTPUT_WIDTH-1:0]       m_data_q, m_data_d, sat;
  logic signed [ACC_W-1:0]       sum, scaled;
`ifdef CONV_ABS_OUT_EN
  logic signed [ACC_W-1:0]       mag;
`endif

  // One enable moves the whole pipeline, including the IDLE drop path.
  assign en      = !m_valid_q || m_ready;
  assign s_ready = en;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
    shift_d = shift_q;
    copy_en = 1'b0;
    acc_px  = s_valid && en && (state_q == RUN || s_sof);
    p_row   = s_sof ? '0 : row_q;
    p_col   = s_sof ? '0 : col_q;
    win_ok  = acc_px && (p_row >= WIN_ROW) && (p_col >= WIN_COL);
    if (acc_px) begin
      if (s_sof) shift_d = scale_shift;
      if (state_q == RUN && s_sof && (row_q != '0 || col_q != '0)) err_d = 1'b1;
      if (p_row == LAST_ROW && p_col == LAST_COL) begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end else begin
        state_d = RUN;
        if (p_col == LAST_COL) begin
          row_d = p_row + 1'b1;
          col_d = '0;
        end else begin
          row_d = p_row;
          col_d = p_col + 1'b1;
        end
      end
    end
    if (coef_commit) begin
      if (state_q == IDLE) copy_en = 1'b1;
      else                 pend_d  = 1'b1;
    end
    // A deferred commit lands on the edge that closes the frame.
    if (state_q == RUN && state_d == IDLE && pend_d) begin
      copy_en = 1'b1;
      pend_d  = 1'b0;
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    if (coef_we && coef_addr < KK_A) shadow_d[coef_addr] = coef_wdata;
    active_d = copy_en ? shadow_d : active_q;
  end

  // Column 0 of the new window column is the oldest row (top).
  always_comb begin
    col_new[K-1] = s_data;
    lb_col_d[0]  = s_data;
    for (int i = 0; i < K - 1; i++) col_new[i] = lb_q[K-2-i][p_col];
    for (int j = 1; j < K - 1; j++) lb_col_d[j] = lb_q[j-1][p_col];
    win_d = win_q;
    if (acc_px) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
        win_d[r][K-1] = col_new[r];
      end
    end
  end

  always_comb begin
    v1_d   = v1_q;
    sof1_d = sof1_q;
    eol1_d = eol1_q;
    eof1_d = eof1_q;
    sh1_d  = sh1_q;
    prod_d = prod_q;
    if (en) begin
      v1_d   = win_ok;
      sof1_d = (p_row == WIN_ROW) && (p_col == WIN_COL);
      eol1_d = (p_col == LAST_COL);
      eof1_d = (p_col == LAST_COL) && (p_row == LAST_ROW);
      sh1_d  = shift_q;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          prod_d[r*K+c] = PROD_W'($signed({1'b0, win_d[r][c]})) * PROD_W'(active_q[r*K+c]);
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < KK; i++) sum = sum + ACC_W'(prod_q[i]);
    scaled = sum >>> sh1_q;
`ifdef CONV_ABS_OUT_EN
    mag = scaled[ACC_W-1] ? -scaled : scaled;
    sat = (mag > SAT_HI) ? SAT_HI[OUTPUT_WIDTH-1:0] : mag[OUTPUT_WIDTH-1:0];
`else
    if (scaled > SAT_HI)      sat = SAT_HI[OUTPUT_WIDTH-1:0];
    else if (scaled < SAT_LO) sat = SAT_LO[OUTPUT_WIDTH-1:0];
    else                      sat = scaled[OUTPUT_WIDTH-1:0];
`endif
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_sof_d   = m_sof_q;
    m_eol_d   = m_eol_q;
    m_eof_d   = m_eof_q;
    if (en) begin
      m_valid_d = v1_q;
      m_data_d  = sat;
      m_sof_d   = v1_q && sof1_q;
      m_eol_d   = v1_q && eol1_q;
      m_eof_d   = v1_q && eof1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      pend_q    <= 1'b0;
      err_q     <= 1'b0;
      shift_q   <= '0;
      v1_q      <= 1'b0;
      sof1_q    <= 1'b0;
      eol1_q    <= 1'b0;
      eof1_q    <= 1'b0;
      sh1_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
      m_eof_q   <= 1'b0;
      for (int i = 0; i < KK; i++) begin
        shadow_q[i] <= COEFF_WIDTH'(i == CENTRE);
        active_q[i] <= COEFF_WIDTH'(i == CENTRE);
        prod_q[i]   <= '0;
      end
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      for (int j = 0; j < K - 1; j++)
        for (int x = 0; x < IMAGE_WIDTH; x++) lb_q[j][x] <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      win_q     <= win_d;
      v1_q      <= v1_d;
      sof1_q    <= sof1_d;
      eol1_q    <= eol1_d;
      eof1_q    <= eof1_d;
      sh1_q     <= sh1_d;
      prod_q    <= prod_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_sof_q   <= m_sof_d;
      m_eol_q   <= m_eol_d;
      m_eof_q   <= m_eof_d;
      if (acc_px)
        for (int j = 0; j < K - 1; j++) lb_q[j][p_col] <= lb_col_d[j];
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_sof     = m_sof_q;
  assign m_eol     = m_eol_q;
  assign m_eof     = m_eof_q;
  assign frame_err = err_q;

endmodule
